flu_wb_arbiter: RTL

Parametrised write-back arbiter for the execute stage. It merges N independent fixed/variable-latency result channels (ALU, CSR buffer, multiplier, and future units) onto a single scoreboard write port. Each channel has a private fall-through FIFO, so a unit is never forced to stall just because the port is busy. Arbitration is round-robin or fixed-priority, with flush support.

---
 rtl/flu_wb_arbiter_pkg.sv | 14 +
 rtl/flu_wb_arbiter_if.sv | 29 ++
 rtl/flu_wb_arbiter_fifo.sv | 47 ++++
 rtl/flu_wb_arbiter.sv | 65 ++++++
 4 files changed

// File: rtl/flu_wb_arbiter_pkg.sv
// flu_wb_arbiter_pkg: shared types, default widths and index helper for the write-back arbiter
package flu_wb_arbiter_pkg;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned NR_WB_PORTS   = 4;
    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;
    function automatic int unsigned wrap_idx(int unsigned base, int unsigned off, int unsigned n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/flu_wb_arbiter_if.sv
// flu_wb_arbiter_if: producer channels plus the single scoreboard write-back port
interface flu_wb_arbiter_if
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrChannels  = NR_WB_PORTS,
    parameter int unsigned DataWidth   = XLEN,
    parameter int unsigned TransIdBits = TRANS_ID_BITS
);
    logic                                   flush_i;
    logic [NrChannels-1:0]                  ch_valid_i;
    logic [NrChannels-1:0]                  ch_ready_o;
    logic [NrChannels-1:0][DataWidth-1:0]   ch_result_i;
    logic [NrChannels-1:0][TransIdBits-1:0] ch_trans_id_i;
    exception_t [NrChannels-1:0]            ch_ex_i;
    logic                                   wb_valid_o;
    logic                                   wb_ready_i;
    logic [DataWidth-1:0]                   wb_result_o;
    logic [TransIdBits-1:0]                 wb_trans_id_o;
    exception_t                             wb_ex_o;
    logic [NrChannels-1:0]                  wb_grant_o;
    modport master (
        output flush_i, ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_i, wb_ready_i,
        input  ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_o, wb_grant_o
    );
    modport slave (
        input  flush_i, ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_i, wb_ready_i,
        output ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_o, wb_grant_o
    );
endinterface

// File: rtl/flu_wb_arbiter_fifo.sv
// flu_wb_arbiter_fifo: fall-through FIFO; when empty, data_i appears on data_o and a same-cycle pop skips storage
module flu_wb_arbiter_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    logic [Depth-1:0][Width-1:0] mem_d, mem_q;
    logic [AW-1:0]               wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]               cnt_d, cnt_q;
    logic                        store, read;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(Depth);
    assign data_o  = empty_o ? data_i : mem_q[rd_ptr_q];
    assign store   = push_i & ~(empty_o & pop_i);
    assign read    = pop_i & ~empty_o;
    always_comb begin
        mem_d = mem_q;
        if (store) mem_d[wr_ptr_q] = data_i;
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(store);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(read);
        cnt_d    = flush_i ? '0 : cnt_q + CW'(store) - CW'(read);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: merges per-channel fall-through FIFOs onto one write-back port (round-robin or fixed priority)
module flu_wb_arbiter
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrChannels  = NR_WB_PORTS,
    parameter int unsigned Depth       = 2,
    parameter int unsigned DataWidth   = XLEN,
    parameter int unsigned TransIdBits = TRANS_ID_BITS,
    parameter bit          FixedPrio   = 1'b0
) (
    input logic             clk_i,
    input logic             rst_ni,
    flu_wb_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(NrChannels);
    typedef struct packed {
        logic [DataWidth-1:0]   result;
        logic [TransIdBits-1:0] trans_id;
        exception_t             ex;
    } entry_t;
    logic [NrChannels-1:0] push, pop, empty, full, req, grant;
    entry_t [NrChannels-1:0] head;
    entry_t                  wb;
    logic [IW-1:0]           rr_d, rr_q, gnt_idx, idx;
    logic                    hs;
    for (genvar i = 0; i < NrChannels; i++) begin : g_ch
        // Reset also masks the bypass path so outputs idle while rst_ni is low
        assign push[i] = bus.ch_valid_i[i] & ~full[i] & ~bus.flush_i & rst_ni;
        assign req[i]  = (~empty[i] | push[i]) & ~bus.flush_i & rst_ni;
        assign pop[i]  = grant[i] & bus.wb_ready_i;
        flu_wb_arbiter_fifo #(.Depth(Depth), .Width($bits(entry_t))) u_fifo (
            .clk_i,
            .rst_ni,
            .flush_i(bus.flush_i),
            .push_i (push[i]),
            .pop_i  (pop[i]),
            .data_i ({bus.ch_result_i[i], bus.ch_trans_id_i[i], bus.ch_ex_i[i]}),
            .data_o (head[i]),
            .empty_o(empty[i]),
            .full_o (full[i])
        );
    end
    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        for (int k = NrChannels - 1; k >= 0; k--) begin
            idx = IW'(wrap_idx(FixedPrio ? 0 : 32'(rr_q), k, NrChannels));
            if (req[idx]) gnt_idx = idx;
        end
        hs    = |req & bus.wb_ready_i;
        grant = |req ? NrChannels'(1) << gnt_idx : '0;
        wb    = |req ? head[gnt_idx] : '0;
        rr_d  = bus.flush_i ? '0 : hs ? IW'(wrap_idx(32'(gnt_idx), 1, NrChannels)) : rr_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_q <= '0;
        else rr_q <= rr_d;
    end
    assign bus.ch_ready_o    = ~full;
    assign bus.wb_valid_o    = |req;
    assign bus.wb_grant_o    = grant;
    assign bus.wb_result_o   = wb.result;
    assign bus.wb_trans_id_o = wb.trans_id;
    assign bus.wb_ex_o       = wb.ex;
endmodule
